sdrd_reader: RTL

SDRD_READER -- requirements
Module: sdrd_reader

---
 rtl/sdrd_pkg.sv | 26 ++
 rtl/sdrd_reader_if.sv | 31 +++
 rtl/sdrd_strobe_timer.sv | 36 +++
 rtl/sdrd_reader.sv | 120 ++++++++++++
 4 files changed

// File: rtl/sdrd_pkg.sv
// Shared types and constants for the SDRD serial reader: FSM states, bus window
// address and parameter defaults. Honours SDRD_READER_PARITY_EN (adds one parity bit per frame).
package sdrd_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_HOLD,
      S_SAMPLE,
      S_GAP,
      S_DONE
   } sdrd_state_e;

   localparam logic BA13_WIN = 1'b0;
   localparam logic BA12_WIN = 1'b1;

   localparam int NBITS_DEF      = 16;
   localparam int STROBE_CYC_DEF = 2;

`ifdef SDRD_READER_PARITY_EN
   localparam int PAR_BITS = 1;
`else
   localparam int PAR_BITS = 0;
`endif

endpackage

// File: rtl/sdrd_reader_if.sv
// Host-side request/result signals and target bus pins of the SDRD reader.
// master = reader (drives the bus), slave = host/target side.
interface sdrd_reader_if
   import sdrd_pkg::*;
#(
   parameter int NBITS = NBITS_DEF
);
   logic             start;
   logic [3:0]       cmd;
   logic             sser_n;
   logic             ba13;
   logic             ba12;
   logic [3:0]       ba_cmd;
   logic             br_w;
   logic             sdrd;
   logic             busy;
   logic [NBITS-1:0] data_o;
   logic             data_valid;
   logic             data_ready;
   logic             par_err;

   modport master (
      input  start, cmd, sdrd, data_ready,
      output sser_n, ba13, ba12, ba_cmd, br_w, busy, data_o, data_valid, par_err
   );

   modport slave (
      output start, cmd, sdrd, data_ready,
      input  sser_n, ba13, ba12, ba_cmd, br_w, busy, data_o, data_valid, par_err
   );
endinterface

// File: rtl/sdrd_strobe_timer.sv
// Counts the select hold time: loaded with STROBE_CYC while in SETUP, counts down
// while enabled, and flags done on the last hold cycle.
module sdrd_strobe_timer
   import sdrd_pkg::*;
#(
   parameter int STROBE_CYC = STROBE_CYC_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load_i,
   input  logic en_i,
   output logic done_o
);
   localparam logic [3:0] LOAD = 4'(STROBE_CYC);

   logic [3:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = LOAD;
      end else if (en_i && cnt_q != 4'd0) begin
         cnt_d = cnt_q - 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign done_o = en_i && (cnt_q == 4'd1);
endmodule

// File: rtl/sdrd_reader.sv
// Serial SDRD reader: strobes the target once per bit and shifts SDRD in MSB first.
// Optional SDRD_READER_PARITY_EN appends an odd-parity bit to every frame.
module sdrd_reader
   import sdrd_pkg::*;
#(
   parameter int NBITS      = NBITS_DEF,
   parameter int STROBE_CYC = STROBE_CYC_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   sdrd_reader_if.master bus
);
   localparam int            SW   = NBITS + PAR_BITS;
   localparam int            CW   = (SW > 1) ? $clog2(SW) : 1;
   localparam logic [CW-1:0] LAST = CW'(SW - 1);

   sdrd_state_e      state_q, state_d;
   logic [3:0]       cmd_q, cmd_d;
   logic [SW-1:0]    sh_q, sh_d;
   logic [CW-1:0]    bit_q, bit_d;
   logic [NBITS-1:0] dout_q, dout_d;
   logic             perr_q, perr_d;
   logic             hold_done;
   logic             drive;

   sdrd_strobe_timer #(
      .STROBE_CYC (STROBE_CYC)
   ) u_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .load_i (state_q == S_SETUP),
      .en_i   (state_q == S_HOLD),
      .done_o (hold_done)
   );

   always_comb begin
      state_d = state_q;
      cmd_d   = cmd_q;
      sh_d    = sh_q;
      bit_d   = bit_q;
      dout_d  = dout_q;
      perr_d  = perr_q;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               state_d = S_SETUP;
               cmd_d   = bus.cmd;
               sh_d    = '0;
               bit_d   = '0;
            end
         end
         S_SETUP:  state_d = S_HOLD;
         S_HOLD:   if (hold_done) state_d = S_SAMPLE;
         S_SAMPLE: begin
            sh_d    = SW'({sh_q, bus.sdrd});
            state_d = S_GAP;
         end
         S_GAP: begin
            if (bit_q == LAST) begin
               state_d = S_DONE;
`ifdef SDRD_READER_PARITY_EN
               // Odd parity: the frame including its parity bit must hold an odd number of ones.
               dout_d  = sh_q[SW-1:1];
               perr_d  = ~(^sh_q);
`else
               dout_d  = sh_q;
               perr_d  = 1'b0;
`endif
            end else begin
               bit_d   = bit_q + 1'b1;
               state_d = S_SETUP;
            end
         end
         S_DONE: begin
            if (bus.data_ready) begin
               perr_d = 1'b0;
               if (bus.start) begin
                  state_d = S_SETUP;
                  cmd_d   = bus.cmd;
                  sh_d    = '0;
                  bit_d   = '0;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cmd_q   <= '0;
         sh_q    <= '0;
         bit_q   <= '0;
         dout_q  <= '0;
         perr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cmd_q   <= cmd_d;
         sh_q    <= sh_d;
         bit_q   <= bit_d;
         dout_q  <= dout_d;
         perr_q  <= perr_d;
      end
   end

   // Bus pins are decoded from state so reset drives them idle on the same edge.
   assign drive          = (state_q == S_SETUP) || (state_q == S_HOLD) || (state_q == S_SAMPLE);
   assign bus.sser_n     = ~drive;
   assign bus.ba13       = drive ? BA13_WIN : 1'b1;
   assign bus.ba12       = drive ? BA12_WIN : 1'b0;
   assign bus.br_w       = drive;
   assign bus.ba_cmd     = drive ? cmd_q : 4'h0;
   assign bus.busy       = (state_q != S_IDLE) && (state_q != S_DONE);
   assign bus.data_valid = (state_q == S_DONE);
   assign bus.data_o     = dout_q;
   assign bus.par_err    = perr_q;
endmodule
